// File: rtl/gpr_file_mp_if.sv
// Bus bundle for the multi-port GPR file.
// Carries the two read ports, two write ports, the flag write and the clear handshake.
interface gpr_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr0_en;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_en;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              flag_we;
  logic              flag_val;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  modport master (
    output rd_addr_a, rd_addr_b,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output flag_we, flag_val, clr_start,
    input  rd_data_a, rd_data_b,
    input  clr_busy, clr_done
  );

  modport slave (
    input  rd_addr_a, rd_addr_b,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  flag_we, flag_val, clr_start,
    output rd_data_a, rd_data_b,
    output clr_busy, clr_done
  );
endinterface

// File: rtl/gpr_file_mp.sv
// Two-read / two-write register file with r0 hardwired to zero,
// an overflow flag bit in FLAG_REG and a one-entry-per-cycle clear sweep.
module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int FLAG_REG = 30
) (
  input  logic          clk,
  input  logic          rst,
  gpr_file_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  logic              wr0_en, wr1_en;
  logic [ADDR_W-1:0] wr0_addr, wr1_addr;
  logic [DATA_W-1:0] wr0_data, wr1_data;
  logic              busy, last_idx;

  assign wr0_en   = bus.wr0_en;
  assign wr0_addr = bus.wr0_addr;
  assign wr0_data = bus.wr0_data;
  assign wr1_en   = bus.wr1_en;
  assign wr1_addr = bus.wr1_addr;
  assign wr1_data = bus.wr1_data;

  assign busy     = (state_q == CLEAR);
  assign last_idx = (clr_idx_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_d     = mem_q;
    unique case (state_q)
      IDLE: begin
        // Port 1 after port 0, flag bit last: later assignment wins.
        for (int i = 1; i < DEPTH; i++) begin
          if (wr0_en && wr0_addr == ADDR_W'(i))
            mem_d[i] = wr0_data;
          if (wr1_en && wr1_addr == ADDR_W'(i))
            mem_d[i] = wr1_data;
          if (bus.flag_we && i == FLAG_REG)
            mem_d[i][0] = bus.flag_val;
        end
        if (bus.clr_start) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end
      end
      CLEAR: begin
        for (int i = 1; i < DEPTH; i++) begin
          if (clr_idx_q == ADDR_W'(i))
            mem_d[i] = '0;
        end
        if (last_idx) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      clr_idx_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      mem_q     <= mem_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] r;
    if (a == '0 || busy)
      r = '0;
    else if (wr1_en && wr1_addr == a)
      r = wr1_data;
    else if (wr0_en && wr0_addr == a)
      r = wr0_data;
    else
      r = mem_q[a];
    return r;
  endfunction

  assign bus.rd_data_a = rd_sel(bus.rd_addr_a);
  assign bus.rd_data_b = rd_sel(bus.rd_addr_b);
  assign bus.clr_busy  = busy;
  assign bus.clr_done  = busy && last_idx;
endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: vector table, clear/reset sequences,
// a narrow 16x8 instance and randomized traffic against a reference model.
module tb_gpr_file_mp;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gpr_file_mp_if #(.DATA_W(32), .ADDR_W(5)) bif ();
  gpr_file_mp_if #(.DATA_W(16), .ADDR_W(3)) sif ();

  gpr_file_mp #(.DATA_W(32), .ADDR_W(5), .FLAG_REG(30)) u_big (
    .clk(clk), .rst(rst), .bus(bif)
  );
  gpr_file_mp #(.DATA_W(16), .ADDR_W(3), .FLAG_REG(6)) u_small (
    .clk(clk), .rst(rst), .bus(sif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic off_b();
    bif.wr0_en = 0; bif.wr0_addr = 0; bif.wr0_data = 0;
    bif.wr1_en = 0; bif.wr1_addr = 0; bif.wr1_data = 0;
    bif.flag_we = 0; bif.flag_val = 0; bif.clr_start = 0;
  endtask

  task automatic off_s();
    sif.wr0_en = 0; sif.wr0_addr = 0; sif.wr0_data = 0;
    sif.wr1_en = 0; sif.wr1_addr = 0; sif.wr1_data = 0;
    sif.flag_we = 0; sif.flag_val = 0; sif.clr_start = 0;
  endtask

  typedef struct {
    logic w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic fwe; logic fv;
    logic [4:0] ra; logic [4:0] rb;
    logic [31:0] pa; logic [31:0] pb;
    logic [31:0] qa; logic [31:0] qb;
  } vec_t;

  vec_t vt[9];

  // Reference model state for the randomized phase.
  logic [31:0] mdl[32];
  int          left;
  logic        r_w0e, r_w1e, r_fwe, r_fv, r_cs;
  logic [4:0]  r_w0a, r_w1a, r_ra, r_rb;
  logic [31:0] r_w0d, r_w1d;

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0 || left > 0) return 32'h0;
    if (r_w1e && r_w1a == a) return r_w1d;
    if (r_w0e && r_w0a == a) return r_w0d;
    return mdl[a];
  endfunction

  int busy_cnt, done_cnt, done_at;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    off_b(); off_s();
    bif.rd_addr_a = 5; bif.rd_addr_b = 30;
    sif.rd_addr_a = 7; sif.rd_addr_b = 6;

    vt[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0,
              32'hDEADBEEF, 0, 32'hDEADBEEF, 0};
    vt[1] = '{1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5,
              32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF};
    vt[2] = '{1, 30, 32'hFFFFFFFE, 0, 0, 0, 1, 1, 30, 7,
              32'hFFFFFFFE, 32'h22, 32'hFFFFFFFF, 32'h22};
    vt[3] = '{0, 0, 0, 0, 0, 0, 1, 0, 30, 5,
              32'hFFFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFE, 32'hDEADBEEF};
    vt[4] = '{1, 0, 32'h1234, 1, 0, 32'h5678, 0, 0, 0, 0,
              0, 0, 0, 0};
    vt[5] = '{1, 9, 32'hAAAA, 1, 10, 32'hBBBB, 0, 0, 9, 10,
              32'hAAAA, 32'hBBBB, 32'hAAAA, 32'hBBBB};
    vt[6] = '{1, 9, 32'hDDDD, 1, 9, 32'hCCCC, 0, 0, 9, 30,
              32'hCCCC, 32'hFFFFFFFE, 32'hCCCC, 32'hFFFFFFFE};
    vt[7] = '{0, 0, 0, 1, 30, 32'h80000000, 1, 1, 30, 9,
              32'h80000000, 32'hCCCC, 32'h80000001, 32'hCCCC};
    vt[8] = '{1, 30, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 30, 0,
              32'hFFFFFFFF, 0, 32'hFFFFFFFE, 0};

    // Reset state
    #3;
    chk("rst_rd_a", bif.rd_data_a, 0);
    chk("rst_rd_b", bif.rd_data_b, 0);
    chk("rst_busy", bif.clr_busy, 0);
    chk("rst_done", bif.clr_done, 0);
    chk("rst_small_rd", sif.rd_data_a, 0);
    @(negedge clk); rst = 1;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bif.wr0_en = vt[i].w0e; bif.wr0_addr = vt[i].w0a;
      bif.wr0_data = vt[i].w0d;
      bif.wr1_en = vt[i].w1e; bif.wr1_addr = vt[i].w1a;
      bif.wr1_data = vt[i].w1d;
      bif.flag_we = vt[i].fwe; bif.flag_val = vt[i].fv;
      bif.rd_addr_a = vt[i].ra; bif.rd_addr_b = vt[i].rb;
      #1;
      chk($sformatf("v%0d_pre_a", i), bif.rd_data_a, vt[i].pa);
      chk($sformatf("v%0d_pre_b", i), bif.rd_data_b, vt[i].pb);
      @(posedge clk); #1;
      off_b();
      #1;
      chk($sformatf("v%0d_post_a", i), bif.rd_data_a, vt[i].qa);
      chk($sformatf("v%0d_post_b", i), bif.rd_data_b, vt[i].qb);
    end

    // Full clear sweep with writes/start attempted mid-sweep
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      bif.wr0_en = 1; bif.wr0_addr = 5'(i);
      bif.wr0_data = 32'h1000_0000 + i;
    end
    @(negedge clk);
    off_b();
    bif.wr1_en = 1; bif.wr1_addr = 2; bif.wr1_data = 32'h77;
    bif.clr_start = 1; bif.rd_addr_a = 31;
    #1;
    chk("clr_pre_busy", bif.clr_busy, 0);
    chk("clr_pre_rd", bif.rd_data_a, 32'h1000001F);
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      off_b();
      bif.rd_addr_a = 5'(c % 31 + 1); bif.rd_addr_b = 2;
      bif.clr_start = (c == 5);
      bif.wr0_en = (c == 6); bif.wr0_addr = 4; bif.wr0_data = 1;
      #1;
      if (!bif.clr_busy) break;
      busy_cnt++;
      chk("clr_rd_zero", bif.rd_data_a, 0);
      if (bif.clr_done) begin done_cnt++; done_at = busy_cnt; end
    end
    off_b();
    chk("clr_busy_cycles", busy_cnt, 32);
    chk("clr_done_count", done_cnt, 1);
    chk("clr_done_at", done_at, 32);
    chk("clr_done_after", bif.clr_done, 0);
    for (int a = 1; a < 32; a++) begin
      bif.rd_addr_a = 5'(a); #1;
      chk($sformatf("clr_r%0d", a), bif.rd_data_a, 0);
    end

    // Reset mid-sweep
    @(negedge clk);
    bif.wr0_en = 1; bif.wr0_addr = 8; bif.wr0_data = 32'h99;
    @(negedge clk);
    off_b(); bif.clr_start = 1;
    @(negedge clk);
    bif.clr_start = 0;
    for (int c = 0; c < 9; c++) @(negedge clk);
    #1 chk("abort_busy_before", bif.clr_busy, 1);
    #1 rst = 0;
    #1;
    chk("abort_busy", bif.clr_busy, 0);
    chk("abort_done", bif.clr_done, 0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      if (bif.clr_done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    @(negedge clk);
    rst = 1;
    bif.wr0_en = 1; bif.wr0_addr = 3; bif.wr0_data = 32'h5;
    bif.rd_addr_a = 3; bif.rd_addr_b = 8;
    @(posedge clk); #1;
    off_b(); #1;
    chk("post_rst_r3", bif.rd_data_a, 32'h5);
    chk("post_rst_r8", bif.rd_data_b, 0);
    chk("post_rst_busy", bif.clr_busy, 0);

    // Narrow instance: port collision, flag, 8-cycle sweep
    @(negedge clk);
    sif.wr0_en = 1; sif.wr0_addr = 7; sif.wr0_data = 16'h11;
    sif.wr1_en = 1; sif.wr1_addr = 7; sif.wr1_data = 16'h22;
    sif.rd_addr_a = 7;
    #1 chk("s_byp", sif.rd_data_a, 32'h22);
    @(posedge clk); #1; off_s(); #1;
    chk("s_r7", sif.rd_data_a, 32'h22);
    @(negedge clk);
    sif.wr0_en = 1; sif.wr0_addr = 6; sif.wr0_data = 16'hFFFE;
    sif.flag_we = 1; sif.flag_val = 1; sif.rd_addr_b = 6;
    @(posedge clk); #1; off_s(); #1;
    chk("s_flag", sif.rd_data_b, 32'hFFFF);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      sif.wr0_en = 1; sif.wr0_addr = 3'(i);
      sif.wr0_data = 16'hF000 | 16'(i);
    end
    @(negedge clk);
    off_s(); sif.clr_start = 1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      off_s(); sif.rd_addr_a = 3'(c % 7 + 1);
      #1;
      if (!sif.clr_busy) break;
      busy_cnt++;
      chk("s_clr_rd_zero", sif.rd_data_a, 0);
      if (sif.clr_done) begin done_cnt++; done_at = busy_cnt; end
    end
    chk("s_busy_cycles", busy_cnt, 8);
    chk("s_done_count", done_cnt, 1);
    chk("s_done_at", done_at, 8);
    for (int a = 1; a < 8; a++) begin
      sif.rd_addr_a = 3'(a); #1;
      chk($sformatf("s_clr_r%0d", a), sif.rd_data_a, 0);
    end

    // Randomized traffic against the reference model
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    left = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      r_w0e = 1'($urandom_range(0, 1));
      r_w0a = 5'($urandom_range(0, 31));
      r_w0d = $urandom;
      r_w1e = 1'($urandom_range(0, 1));
      r_w1a = ($urandom_range(0, 3) == 0) ? r_w0a : 5'($urandom_range(0, 31));
      r_w1d = $urandom;
      r_fwe = ($urandom_range(0, 3) == 0);
      r_fv  = 1'($urandom_range(0, 1));
      r_cs  = ($urandom_range(0, 59) == 0);
      r_ra  = $urandom_range(0, 1) ? r_w0a : 5'($urandom_range(0, 31));
      r_rb  = $urandom_range(0, 1) ? r_w1a : 5'($urandom_range(0, 31));
      bif.wr0_en = r_w0e; bif.wr0_addr = r_w0a; bif.wr0_data = r_w0d;
      bif.wr1_en = r_w1e; bif.wr1_addr = r_w1a; bif.wr1_data = r_w1d;
      bif.flag_we = r_fwe; bif.flag_val = r_fv; bif.clr_start = r_cs;
      bif.rd_addr_a = r_ra; bif.rd_addr_b = r_rb;
      #1;
      chk("rnd_rd_a", bif.rd_data_a, exp_rd(r_ra));
      chk("rnd_rd_b", bif.rd_data_b, exp_rd(r_rb));
      chk("rnd_busy", bif.clr_busy, left > 0);
      chk("rnd_done", bif.clr_done, left == 1);
      if (left > 0) begin
        left--;
        if (left == 0)
          for (int i = 0; i < 32; i++) mdl[i] = 0;
      end else begin
        if (r_w0e && r_w0a != 0) mdl[r_w0a] = r_w0d;
        if (r_w1e && r_w1a != 0) mdl[r_w1a] = r_w1d;
        if (r_fwe) mdl[30][0] = r_fv;
        if (r_cs) left = 32;
      end
    end
    @(negedge clk);
    off_b();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpr_file_mp.md
GPR_FILE_MP -- requirements
Module: gpr_file_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter FLAG_REG, default 30, index of the entry whose bit 0 is the overflow flag.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 rd_addr_a, rd_addr_b  input  ADDR_W  read port A/B addresses.
REQ-007 rd_data_a, rd_data_b  output  DATA_W  read port A/B data, combinational.
REQ-008 wr0_en, wr1_en  input  1  write port 0/1 enables.
REQ-009 wr0_addr, wr1_addr  input  ADDR_W  write port 0/1 addresses.
REQ-010 wr0_data, wr1_data  input  DATA_W  write port 0/1 data.
REQ-011 flag_we  input  1  overflow-flag write enable.
REQ-012 flag_val  input  1  overflow-flag value.
REQ-013 clr_start  input  1  request a full-array clear sweep.
REQ-014 clr_busy  output  1  high while the clear sweep runs.
REQ-015 clr_done  output  1  one-cycle pulse when the sweep completes.

Function
REQ-016 Entry 0 SHALL read as 0 on both ports and SHALL ignore all writes, including flag writes when FLAG_REG = 0.
REQ-017 Each read port SHALL return, in priority order: 0 if addr = 0; 0 if clr_busy; wr1_data if wr1_en and wr1_addr = rd_addr; wr0_data if wr0_en and wr0_addr = rd_addr; otherwise the stored entry.
REQ-018 Read bypass SHALL apply to the full word; a pending flag_we SHALL NOT be bypassed.
REQ-019 On a rising edge with wr0_en, entry wr0_addr SHALL take wr0_data; the same applies to port 1.
REQ-020 When both ports write the same address in one cycle, port 1 SHALL win.
REQ-021 On a rising edge with flag_we, bit 0 of entry FLAG_REG SHALL take flag_val, applied after the port writes, so the flag overrides bit 0 of a same-cycle word write to FLAG_REG; bits DATA_W-1:1 follow REQ-019/020.
REQ-022 The FSM SHALL have states IDLE and CLEAR, plus a clear counter clr_idx of ADDR_W bits.
REQ-023 In IDLE, clr_start SHALL move the FSM to CLEAR with clr_idx = 0; clr_busy SHALL rise on the next cycle.
REQ-024 In CLEAR, each cycle SHALL zero entry clr_idx and increment clr_idx.
REQ-025 When clr_idx = DEPTH-1 is cleared, the FSM SHALL return to IDLE and pulse clr_done in that same cycle, so the sweep takes exactly DEPTH cycles.
REQ-026 While in CLEAR, all writes (wr0, wr1, flag) SHALL be discarded and clr_start SHALL be ignored.
REQ-027 clr_start asserted in the same cycle as writes in IDLE: the writes SHALL commit, and the sweep SHALL then erase them.
REQ-028 clr_idx SHALL NOT wrap past DEPTH-1; no entry SHALL be cleared twice per sweep.

Reset
REQ-029 While rst = 0, all entries SHALL be 0, FSM = IDLE, clr_idx = 0, clr_busy = 0 and clr_done = 0, independent of clk.
REQ-030 Reset asserted mid-sweep SHALL abort the sweep immediately, with no clr_done pulse.
REQ-031 On the first rising edge after rst deasserts, writes SHALL be accepted normally.

Verification
REQ-032 Write 0xDEADBEEF to r5 via wr0, then read A = 5 next cycle -> 0xDEADBEEF; read B = 0 -> 0.
REQ-033 Same cycle: wr0 r7 = 0x11, wr1 r7 = 0x22, read A = 7 -> bypass 0x22; after the edge r7 = 0x22.
REQ-034 wr0 r30 = 0xFFFFFFFE with flag_we = 1, flag_val = 1 -> r30 = 0xFFFFFFFF; then flag_we = 1, flag_val = 0 alone -> r30 = 0xFFFFFFFE.
REQ-035 Fill r1..r31 with nonzero values, pulse clr_start -> clr_busy high for 32 cycles, reads return 0 throughout, clr_done pulses once, then all entries read 0.
REQ-036 Start a sweep, drop rst at sweep cycle 10 -> clr_busy = 0 at once with no clr_done; after release, write r3 = 0x5 -> reads 0x5.
REQ-037 With DATA_W = 16 and ADDR_W = 3, repeat REQ-033 and REQ-035 -> sweep lasts 8 cycles and widths are respected.
